// File: rtl/adcdac_2g_pkg.sv
// Shared constants, status codes and FSM encoding for the 2G control-link command framer.
// Frame layout on both directions: sync, {rw,addr}, data_hi, data_lo, xor of bytes 1..3.
package adcdac_2g_pkg;

   localparam logic [7:0] SYNC_TX_DEF = 8'hA5;
   localparam logic [7:0] SYNC_RX_DEF = 8'h5A;
   localparam int         FRAME_LEN   = 5;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_CHECKSUM = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ADDR     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_RSP = 2'd2
   } state_e;

   function automatic logic [7:0] frame_chk(input logic [7:0] b1,
                                            input logic [7:0] b2,
                                            input logic [7:0] b3);
      return b1 ^ b2 ^ b3;
   endfunction

endpackage

// File: rtl/adcdac_2g_rsp_parser.sv
// Reply-frame parser: hunts the RX sync byte, collects B1..B3 and checks B4 as it arrives.
// Held cleared while i_en is low so every wait period starts hunting from scratch.
module adcdac_2g_rsp_parser
   import adcdac_2g_pkg::*;
#(
   parameter logic [7:0] SYNC_RX = SYNC_RX_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic        i_rx_val,
   input  logic [7:0]  i_rx_data,
   output logic        o_frame_done,
   output logic        o_chk_err,
   output logic [7:0]  o_b1,
   output logic [15:0] o_data,
   output logic        o_stray
);
   localparam logic [2:0] POS_HUNT = 3'd0;
   localparam logic [2:0] POS_B4   = 3'(FRAME_LEN - 1);

   logic [2:0] r_pos;
   logic [7:0] r_b1;
   logic [7:0] r_b2;
   logic [7:0] r_b3;
   logic       w_byte;

   assign w_byte = i_en & i_rx_val;

   // Position 0 hunts for sync; once synced, bytes are taken positionally (no mid-frame resync).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pos <= POS_HUNT;
         r_b1  <= 8'h00;
         r_b2  <= 8'h00;
         r_b3  <= 8'h00;
      end else if (!i_en) begin
         r_pos <= POS_HUNT;
         r_b1  <= 8'h00;
         r_b2  <= 8'h00;
         r_b3  <= 8'h00;
      end else if (i_rx_val) begin
         case (r_pos)
            3'd0: if (i_rx_data == SYNC_RX) r_pos <= 3'd1;
            3'd1: begin r_b1 <= i_rx_data; r_pos <= 3'd2; end
            3'd2: begin r_b2 <= i_rx_data; r_pos <= 3'd3; end
            3'd3: begin r_b3 <= i_rx_data; r_pos <= POS_B4; end
            default: r_pos <= POS_HUNT;
         endcase
      end
   end

   assign o_frame_done = w_byte & (r_pos == POS_B4);
   assign o_chk_err    = (i_rx_data != frame_chk(r_b1, r_b2, r_b3));
   assign o_b1         = r_b1;
   assign o_data       = {r_b2, r_b3};
   assign o_stray      = w_byte & (r_pos == POS_HUNT) & (i_rx_data != SYNC_RX);

endmodule

// File: rtl/adcdac_2g_cmd_framer.sv
// Register-access framer for the 2G control link: one command out as a 5-byte frame,
// one 5-byte reply parsed back into read data and a status code, with a reply timeout.
module adcdac_2g_cmd_framer
   import adcdac_2g_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter logic [7:0]  SYNC_TX     = SYNC_TX_DEF,
   parameter logic [7:0]  SYNC_RX     = SYNC_RX_DEF
) (
   input  logic        fpga_clk,
   input  logic        fpga_rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rw,
   input  logic [6:0]  cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic        busy,
   output logic [7:0]  stray_cnt,
   output logic [7:0]  user_tx_data,
   output logic        user_tx_val,
   input  logic        user_tx_full,
   input  logic [7:0]  user_rx_data,
   input  logic        user_rx_val
);
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYC - 1);
   localparam logic [2:0]  IDX_LAST = 3'(FRAME_LEN - 1);

   state_e      r_state;
   logic        r_rw;
   logic [6:0]  r_addr;
   logic [15:0] r_wdata;
   logic [2:0]  r_idx;
   logic [23:0] r_timer;
   logic        r_rsp_valid;
   logic [15:0] r_rsp_rdata;
   logic [1:0]  r_rsp_err;
   logic [7:0]  r_stray_cnt;

   logic        w_tx_val;
   logic [7:0]  w_tx_byte;
   logic        w_parser_en;
   logic        w_frame_done;
   logic        w_chk_err;
   logic [7:0]  w_rx_b1;
   logic [15:0] w_rx_data;
   logic        w_parser_stray;
   logic        w_stray;

   assign cmd_ready    = (r_state == ST_IDLE);
   assign busy         = ~cmd_ready;
   assign w_tx_val     = (r_state == ST_SEND) & ~user_tx_full;
   assign user_tx_val  = w_tx_val;
   assign user_tx_data = (r_state == ST_SEND) ? w_tx_byte : 8'h00;
   assign w_parser_en  = (r_state == ST_WAIT_RSP);
   assign w_stray      = w_parser_stray | (user_rx_val & ~w_parser_en);
   assign rsp_valid    = r_rsp_valid;
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_err      = r_rsp_err;
   assign stray_cnt    = r_stray_cnt;

   always_comb begin
      w_tx_byte = SYNC_TX;
      case (r_idx)
         3'd0:    w_tx_byte = SYNC_TX;
         3'd1:    w_tx_byte = {r_rw, r_addr};
         3'd2:    w_tx_byte = r_wdata[15:8];
         3'd3:    w_tx_byte = r_wdata[7:0];
         default: w_tx_byte = frame_chk({r_rw, r_addr}, r_wdata[15:8], r_wdata[7:0]);
      endcase
   end

   adcdac_2g_rsp_parser #(
      .SYNC_RX (SYNC_RX)
   ) u_parser (
      .i_clk        (fpga_clk),
      .i_rst_n      (fpga_rst_n),
      .i_en         (w_parser_en),
      .i_rx_val     (user_rx_val),
      .i_rx_data    (user_rx_data),
      .o_frame_done (w_frame_done),
      .o_chk_err    (w_chk_err),
      .o_b1         (w_rx_b1),
      .o_data       (w_rx_data),
      .o_stray      (w_parser_stray)
   );

   always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         r_state     <= ST_IDLE;
         r_rw        <= 1'b0;
         r_addr      <= 7'h00;
         r_wdata     <= 16'h0000;
         r_idx       <= 3'd0;
         r_timer     <= 24'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 16'h0000;
         r_rsp_err   <= ERR_OK;
         r_stray_cnt <= 8'h00;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_stray && (r_stray_cnt != 8'hFF)) r_stray_cnt <= r_stray_cnt + 8'd1;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_rw    <= cmd_rw;
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_rw ? 16'h0000 : cmd_wdata;
                  r_idx   <= 3'd0;
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (w_tx_val) begin
                  if (r_idx == IDX_LAST) begin
                     r_timer <= 24'd0;
                     r_state <= ST_WAIT_RSP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end
            end
            ST_WAIT_RSP: begin
               r_timer <= r_timer + 24'd1;
               // A completed reply beats a timeout landing on the same cycle.
               if (w_frame_done) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= w_rx_data;
                  r_rsp_err   <= w_chk_err ? ERR_CHECKSUM :
                                 (w_rx_b1 != {r_rw, r_addr}) ? ERR_ADDR : ERR_OK;
                  r_state     <= ST_IDLE;
               end else if (r_timer == TMO_LAST) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= 16'h0000;
                  r_rsp_err   <= ERR_TIMEOUT;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
